instr_fetch_queue: RTL and testbench

//  Fetch stage feeding the single-cycle decode/execute core. Owns the PC and issues

---
 rtl/cpu_pkg.sv | 11 +
 rtl/fetch_fifo.sv | 46 ++++
 rtl/instr_fetch_queue.sv | 79 +++++++
 tb/tb_instr_fetch_queue.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared word width, PC step, fetch FSM encoding and PC alignment helper
package cpu_pkg;
    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] PC_STEP = 32'd4;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;
    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] a);
        return a & ~WORD_W'(3);
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with wrap-around pointers and flush
// Ports: clk/rst (async active-high), i_push/i_data write, i_pop read,
//        i_flush empties the queue, o_head is the head entry, o_count the fill level.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp, r_rp;
    logic [CW-1:0]    r_cnt;
    logic             w_push, w_pop;
    assign w_push  = i_push & (r_cnt != CW'(DEPTH));
    assign w_pop   = i_pop & (r_cnt != '0);
    assign o_head  = r_mem[r_rp];
    assign o_count = r_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= i_data;
                r_wp        <= r_wp + AW'(1);
            end
            if (w_pop) r_rp <= r_rp + AW'(1);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: PC owner issuing imem reads and buffering {pc,instr} for decode
// Ports: clock/reset (async active-high); imem_req/imem_addr/imem_ack/imem_rdata
//        memory handshake; redirect/redirect_pc restart fetch; out_valid/out_ready/
//        out_instr/out_pc decode handshake; fill_count FIFO occupancy.
module instr_fetch_queue
    import cpu_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [WORD_W-1:0] RESET_PC = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [WORD_W-1:0]      imem_addr,
    input  logic                   imem_ack,
    input  logic [WORD_W-1:0]      imem_rdata,
    input  logic                   redirect,
    input  logic [WORD_W-1:0]      redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_W-1:0]      out_instr,
    output logic [WORD_W-1:0]      out_pc,
    output logic [$clog2(DEPTH):0] fill_count
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [1:0]          r_state;
    logic                r_req;
    logic [WORD_W-1:0]   r_addr, r_pc;
    logic                w_pop, w_push, w_credit;
    logic [2*WORD_W-1:0] w_head;
    assign imem_req  = r_req;
    assign imem_addr = r_addr;
    assign out_valid = fill_count != '0;
    assign out_pc    = w_head[2*WORD_W-1:WORD_W];
    assign out_instr = w_head[WORD_W-1:0];
    assign w_pop     = out_valid & out_ready & ~redirect;
    // Only data for a live (non-discarded) request is queued; redirect wins over push.
    assign w_push    = (r_state == ST_WAIT) & imem_ack & ~redirect;
    // A new request needs a free slot once this cycle's pop is accounted for.
    assign w_credit  = (fill_count - CW'(w_pop)) < CW'(DEPTH);
    fetch_fifo #(.WIDTH(2 * WORD_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clock),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .i_data  ({r_addr, imem_rdata}),
        .o_head  (w_head),
        .o_count (fill_count)
    );
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_addr  <= RESET_PC;
            r_pc    <= RESET_PC;
        end else begin
            if (redirect) r_pc <= word_align(redirect_pc);
            else if (w_push) r_pc <= r_pc + PC_STEP;
            case (r_state)
                ST_IDLE: if (!redirect && w_credit) begin
                    r_state <= ST_WAIT;
                    r_req   <= 1'b1;
                    r_addr  <= r_pc;
                end
                // An outstanding request cannot be withdrawn; a redirect only marks its data stale.
                ST_WAIT: if (imem_ack) begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                end else if (redirect) r_state <= ST_DISCARD;
                ST_DISCARD: if (imem_ack) begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed checks of fetch, credit, redirect, wrap and reset
module tb_instr_fetch_queue;
    logic clk = 1'b0;
    logic rst;
    logic auto_ack, man_ack, ack1, ready, ready1, redirect;
    logic [31:0] redirect_pc;
    logic        req0, req1, val0, val1;
    logic [31:0] addr0, addr1, pc0, pc1, ins0, ins1, rd0, rd1;
    logic [2:0]  cnt0, cnt1;
    logic        ack0;
    int n = 0;
    int errs = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    assign ack0 = auto_ack ? req0 : man_ack;
    assign rd0  = mem_word(addr0);
    assign rd1  = mem_word(addr1);

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) u0 (
        .clock(clk), .reset(rst), .imem_req(req0), .imem_addr(addr0), .imem_ack(ack0),
        .imem_rdata(rd0), .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(val0),
        .out_ready(ready), .out_instr(ins0), .out_pc(pc0), .fill_count(cnt0)
    );

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u1 (
        .clock(clk), .reset(rst), .imem_req(req1), .imem_addr(addr1), .imem_ack(ack1),
        .imem_rdata(rd1), .redirect(1'b0), .redirect_pc(32'h0), .out_valid(val1),
        .out_ready(ready1), .out_instr(ins1), .out_pc(pc1), .fill_count(cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; auto_ack = 1'b0; man_ack = 1'b0; ack1 = 1'b0;
        ready = 1'b0; ready1 = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", {31'b0, req0}, 32'h0);
        chk("rst_valid", {31'b0, val0}, 32'h0);
        chk("rst_count", {29'b0, cnt0}, 32'h0);
        chk("rst_addr", addr0, 32'h0);
        chk("rst_pc", pc0, 32'h0);
        chk("rst_instr", ins0, 32'h0);
        chk("rst_addr_u1", addr1, 32'hFFFF_FFF8);
        // 1: streaming with immediate ack and ready
        rst = 1'b0; auto_ack = 1'b1; ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t1_req", {31'b0, req0}, 32'h1);
            chk("t1_addr", addr0, 32'(4 * k));
            chk("t1_gap_valid", {31'b0, val0}, 32'h0);
            tick();
            chk("t1_valid", {31'b0, val0}, 32'h1);
            chk("t1_pc", pc0, 32'(4 * k));
            chk("t1_instr", ins0, mem_word(32'(4 * k)));
            chk("t1_count", {29'b0, cnt0}, 32'h1);
        end
        // 2: decode stalled, FIFO fills, credit stops requests
        ready = 1'b0;
        repeat (10) tick();
        chk("t2_full", {29'b0, cnt0}, 32'h4);
        chk("t2_req_off", {31'b0, req0}, 32'h0);
        chk("t2_head", pc0, 32'hC);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("t2_cnt_after_pop", {29'b0, cnt0}, 32'h3);
        chk("t2_new_req", {31'b0, req0}, 32'h1);
        chk("t2_new_addr", addr0, 32'h1C);
        chk("t2_new_head", pc0, 32'h10);
        tick();
        chk("t2_refill", {29'b0, cnt0}, 32'h4);
        for (int k = 0; k < 4; k++) begin
            chk("t2_req_stays_off", {31'b0, req0}, 32'h0);
            tick();
        end
        // 3: redirect during WAIT, ack delayed
        auto_ack = 1'b0; ready = 1'b1;
        tick();
        chk("t3_req", {31'b0, req0}, 32'h1);
        chk("t3_addr", addr0, 32'h20);
        redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        chk("t3_flush_cnt", {29'b0, cnt0}, 32'h0);
        chk("t3_flush_valid", {31'b0, val0}, 32'h0);
        chk("t3_held_req", {31'b0, req0}, 32'h1);
        chk("t3_held_addr", addr0, 32'h20);
        tick();
        chk("t3_held_addr2", addr0, 32'h20);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        chk("t3_drop_req", {31'b0, req0}, 32'h0);
        chk("t3_drop_cnt", {29'b0, cnt0}, 32'h0);
        tick();
        chk("t3_new_req", {31'b0, req0}, 32'h1);
        chk("t3_new_addr", addr0, 32'h100);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        chk("t3_out_valid", {31'b0, val0}, 32'h1);
        chk("t3_out_pc", pc0, 32'h100);
        chk("t3_out_instr", ins0, mem_word(32'h100));
        // 4: redirect with simultaneous ack and pop, two entries queued
        ready = 1'b0;
        tick();
        chk("t4_addr_a", addr0, 32'h104);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        tick();
        chk("t4_two", {29'b0, cnt0}, 32'h2);
        chk("t4_addr_b", addr0, 32'h108);
        man_ack = 1'b1; ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h203;
        tick();
        man_ack = 1'b0; ready = 1'b0; redirect = 1'b0;
        chk("t4_cnt", {29'b0, cnt0}, 32'h0);
        chk("t4_valid", {31'b0, val0}, 32'h0);
        chk("t4_req_low", {31'b0, req0}, 32'h0);
        tick();
        chk("t4_new_addr", addr0, 32'h200);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        chk("t4_out_pc", pc0, 32'h200);
        // 5: PC wrap on the second instance
        chk("t5_req", {31'b0, req1}, 32'h1);
        chk("t5_addr0", addr1, 32'hFFFF_FFF8);
        ack1 = 1'b1;
        tick();
        ack1 = 1'b0;
        chk("t5_pc0", pc1, 32'hFFFF_FFF8);
        chk("t5_instr0", ins1, mem_word(32'hFFFF_FFF8));
        tick();
        chk("t5_addr1", addr1, 32'hFFFF_FFFC);
        ack1 = 1'b1;
        tick();
        ack1 = 1'b0;
        chk("t5_cnt", {29'b0, cnt1}, 32'h2);
        tick();
        chk("t5_wrap_addr", addr1, 32'h0);
        ready1 = 1'b1;
        tick();
        ready1 = 1'b0;
        chk("t5_pc1", pc1, 32'hFFFF_FFFC);
        // 6: reset while a request is outstanding
        chk("t6_pre_req", {31'b0, req0}, 32'h1);
        chk("t6_pre_valid", {31'b0, val0}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("t6_req_now", {31'b0, req0}, 32'h0);
        chk("t6_valid_now", {31'b0, val0}, 32'h0);
        chk("t6_cnt_now", {29'b0, cnt0}, 32'h0);
        man_ack = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick();
        man_ack = 1'b0;
        chk("t6_late_ack_cnt", {29'b0, cnt0}, 32'h0);
        chk("t6_restart_req", {31'b0, req0}, 32'h1);
        chk("t6_restart_addr", addr0, 32'h0);
        chk("t6_u1_addr", addr1, 32'hFFFF_FFF8);
        $display("== %0d vectors applied, %0d miscompares ==", n, errs);
        $finish;
    end
endmodule
